shift_seq_ctrl: RTL and testbench

Sequencing and flag stage for the integer shift/rotate path. Accepts one x86-style shift or rotate per transaction over a valid/ready handshake. Drives the external combinational left-shift array through the `sh_*` ports: right shifts use bit reversal, and rotates use two passes. Merges the pass results, computes the architectural flags, and holds the result for the writeback consumer.

---
 rtl/shift_seq_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Shift/rotate sequencer: drives an external left-shift array, merges passes, computes flags.
// Optional: define SHIFT_SEQ_ROT_EN to build ROL/ROR support (PASS2 + partial-result register).
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       in_cnt,
    output logic [AMT_W-1:0] sh_amt,
    output logic             sh_sin,
    output logic [WIDTH-1:0] sh_in,
    input  logic [WIDTH-1:0] sh_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_flags,
    output logic [4:0]       out_flag_mask
);

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SAR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam int         MSB    = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   d_q;
    logic [AMT_W-1:0]   n_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [4:0]         out_flags_q;
    logic [4:0]         out_mask_q;
`ifdef SHIFT_SEQ_ROT_EN
    logic [WIDTH-1:0]   part_q;
`endif

    logic [AMT_W-1:0]   n_in;
    logic [AMT_W-1:0]   rot_k;
    logic [WIDTH-1:0]   res_d;
    logic [4:0]         sh_flags_d;
    logic [4:0]         rot_flags_d;

    assign n_in = in_cnt[AMT_W-1:0];

    generate
        if (AMT_W < 8) begin : g_cnt_sink
            logic unused_cnt_hi;
            assign unused_cnt_hi = ^in_cnt[7:AMT_W];
        end
    endgenerate

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[MSB-i];
        return r;
    endfunction

    function automatic logic legal(input logic [2:0] op);
        logic ok;
        ok = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
`ifdef SHIFT_SEQ_ROT_EN
        ok = ok || (op == OP_ROL) || (op == OP_ROR);
`endif
        return ok;
    endfunction

    function automatic logic is_rot(input logic [2:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    assign in_ready      = (state_q == IDLE) && !rst;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_flags     = out_flags_q;
    assign out_flag_mask = out_mask_q;

    // ROR by n is ROL by WIDTH-n; the subtraction wraps modulo 2^AMT_W.
    assign rot_k = (op_q == OP_ROR) ? (AMT_W'(WIDTH) - n_q) : n_q;

    always_comb begin
        sh_in  = '0;
        sh_amt = '0;
        sh_sin = 1'b0;
        case (state_q)
            PASS1: begin
                case (op_q)
                    OP_SHL: begin
                        sh_in  = d_q;
                        sh_amt = n_q;
                    end
                    OP_SHR: begin
                        sh_in  = rev(d_q);
                        sh_amt = n_q;
                    end
                    OP_SAR: begin
                        sh_in  = rev(d_q);
                        sh_amt = n_q;
                        sh_sin = d_q[MSB];
                    end
`ifdef SHIFT_SEQ_ROT_EN
                    OP_ROL, OP_ROR: begin
                        sh_in  = d_q;
                        sh_amt = rot_k;
                    end
`endif
                    default: ;
                endcase
            end
`ifdef SHIFT_SEQ_ROT_EN
            PASS2: begin
                sh_in  = rev(d_q);
                sh_amt = AMT_W'(WIDTH) - rot_k;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        logic cf;
        logic of;
        res_d = (op_q == OP_SHL) ? sh_out : rev(sh_out);
`ifdef SHIFT_SEQ_ROT_EN
        if (state_q == PASS2) res_d = part_q | rev(sh_out);
`endif
        // Shift flags: CF is the last bit shifted out of the original operand.
        if (op_q == OP_SHL) cf = d_q[AMT_W'(WIDTH) - n_q];
        else                cf = d_q[n_q - AMT_W'(1)];
        of = 1'b0;
        if (n_q == AMT_W'(1)) begin
            if (op_q == OP_SHL)      of = res_d[MSB] ^ cf;
            else if (op_q == OP_SHR) of = d_q[MSB];
        end
        sh_flags_d = {of, res_d[MSB], (res_d == '0), ~^res_d[7:0], cf};

        if (op_q == OP_ROL) begin
            cf = res_d[0];
            of = res_d[MSB] ^ cf;
        end else begin
            cf = res_d[MSB];
            of = res_d[MSB] ^ res_d[MSB-1];
        end
        if (n_q != AMT_W'(1)) of = 1'b0;
        rot_flags_d = {of, 3'b000, cf};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            d_q         <= '0;
            n_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
            out_mask_q  <= '0;
`ifdef SHIFT_SEQ_ROT_EN
            part_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= in_op;
                        d_q  <= in_data;
                        n_q  <= n_in;
                        if (n_in == '0 || !legal(in_op)) begin
                            out_data_q  <= in_data;
                            out_flags_q <= '0;
                            out_mask_q  <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= PASS1;
                        end
                    end
                end
                PASS1: begin
`ifdef SHIFT_SEQ_ROT_EN
                    if (is_rot(op_q)) begin
                        part_q  <= sh_out;
                        state_q <= PASS2;
                    end else
`endif
                    begin
                        out_data_q  <= res_d;
                        out_flags_q <= sh_flags_d;
                        out_mask_q  <= 5'b11111;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
`ifdef SHIFT_SEQ_ROT_EN
                PASS2: begin
                    out_data_q  <= res_d;
                    out_flags_q <= rot_flags_d;
                    out_mask_q  <= 5'b10001;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SHIFT_SEQ_ROT_EN
    logic unused_rot;
    assign unused_rot = is_rot(op_q) ^ (^rot_flags_d) ^ (^rot_k);
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural left-shift array on the sh_* ports.
module tb_shift_seq_ctrl;
    localparam int W = 32;
    localparam int A = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, sh_sin;
    logic [2:0]   in_op;
    logic [W-1:0] in_data, sh_in, sh_out, out_data;
    logic [7:0]   in_cnt;
    logic [A-1:0] sh_amt;
    logic [4:0]   out_flags, out_flag_mask;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] o_data;
    logic [4:0]   o_flags, o_mask;
    int           o_lat;

    always #5 clk = ~clk;

    // External shifter: left shift, vacated low bits filled with sh_sin.
    assign sh_out = (sh_in << sh_amt) | (sh_sin ? ~({W{1'b1}} << sh_amt) : '0);

    shift_seq_ctrl #(.WIDTH(W), .AMT_W(A)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .in_cnt(in_cnt),
        .sh_amt(sh_amt), .sh_sin(sh_sin), .sh_in(sh_in), .sh_out(sh_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_flag_mask(out_flag_mask)
    );

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] d, input logic [7:0] cnt);
        int guard = 0;
        while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_op = op; in_data = d; in_cnt = cnt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        o_lat = 1;
        while (!out_valid && o_lat < 20) begin @(posedge clk); #1; o_lat++; end
        o_data = out_data; o_flags = out_flags; o_mask = out_flag_mask;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_data = '0; in_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
        checks++; if ({out_flags, out_flag_mask} !== 10'd0) begin errors++; $display("FAIL rst_flags got %b/%b want 0", out_flags, out_flag_mask); end
        checks++; if ({sh_in, sh_amt, sh_sin} !== '0) begin errors++; $display("FAIL rst_sh got %h/%h/%b want 0", sh_in, sh_amt, sh_sin); end
        rst = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_shl();
        run_op(3'b000, 32'h8000_0001, 8'd1);
        checks++; if (o_data !== 32'h0000_0002) begin errors++; $display("FAIL shl_data got %h want 00000002", o_data); end
        checks++; if (o_flags !== 5'b10001) begin errors++; $display("FAIL shl_flags got %b want 10001", o_flags); end
        checks++; if (o_mask !== 5'b11111) begin errors++; $display("FAIL shl_mask got %b want 11111", o_mask); end
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL shl_latency got %0d want 2", o_lat); end
        consume();
        // Count 33 masks to 1.
        run_op(3'b000, 32'h4000_0000, 8'd33);
        checks++; if (o_data !== 32'h8000_0000) begin errors++; $display("FAIL shl_mask33_data got %h want 80000000", o_data); end
        checks++; if (o_flags !== 5'b11010) begin errors++; $display("FAIL shl_mask33_flags got %b want 11010", o_flags); end
        consume();
    endtask

    task automatic test_right_shifts();
        run_op(3'b010, 32'h8000_0000, 8'd4);
        checks++; if (o_data !== 32'hF800_0000) begin errors++; $display("FAIL sar_data got %h want f8000000", o_data); end
        checks++; if (o_flags !== 5'b01010) begin errors++; $display("FAIL sar_flags got %b want 01010", o_flags); end
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL sar_latency got %0d want 2", o_lat); end
        consume();
        run_op(3'b001, 32'h8000_0000, 8'd4);
        checks++; if (o_data !== 32'h0800_0000) begin errors++; $display("FAIL shr_data got %h want 08000000", o_data); end
        checks++; if (o_flags !== 5'b00010) begin errors++; $display("FAIL shr_flags got %b want 00010", o_flags); end
        consume();
        run_op(3'b001, 32'h0000_000F, 8'd4);
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL shr_zero_data got %h want 00000000", o_data); end
        checks++; if (o_flags !== 5'b00111) begin errors++; $display("FAIL shr_zero_flags got %b want 00111", o_flags); end
        consume();
        run_op(3'b001, 32'h8000_0003, 8'd1);
        checks++; if (o_data !== 32'h4000_0001) begin errors++; $display("FAIL shr1_data got %h want 40000001", o_data); end
        checks++; if (o_flags !== 5'b10001) begin errors++; $display("FAIL shr1_flags got %b want 10001", o_flags); end
        consume();
        run_op(3'b010, 32'h8000_0002, 8'd1);
        checks++; if (o_data !== 32'hC000_0001) begin errors++; $display("FAIL sar1_data got %h want c0000001", o_data); end
        checks++; if (o_flags !== 5'b01000) begin errors++; $display("FAIL sar1_flags got %b want 01000", o_flags); end
        consume();
    endtask

    task automatic test_rotate();
`ifdef SHIFT_SEQ_ROT_EN
        run_op(3'b011, 32'h8000_0001, 8'd4);
        checks++; if (o_data !== 32'h0000_0018) begin errors++; $display("FAIL rol_data got %h want 00000018", o_data); end
        checks++; if (o_flags !== 5'b00000) begin errors++; $display("FAIL rol_flags got %b want 00000", o_flags); end
        checks++; if (o_mask !== 5'b10001) begin errors++; $display("FAIL rol_mask got %b want 10001", o_mask); end
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL rol_latency got %0d want 3", o_lat); end
        consume();
        run_op(3'b100, 32'h0000_0001, 8'd1);
        checks++; if (o_data !== 32'h8000_0000) begin errors++; $display("FAIL ror_data got %h want 80000000", o_data); end
        checks++; if (o_flags !== 5'b10001) begin errors++; $display("FAIL ror_flags got %b want 10001", o_flags); end
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL ror_latency got %0d want 3", o_lat); end
        consume();
        run_op(3'b100, 32'h0000_0018, 8'd4);
        checks++; if (o_data !== 32'h8000_0001) begin errors++; $display("FAIL ror4_data got %h want 80000001", o_data); end
        checks++; if (o_flags !== 5'b00001) begin errors++; $display("FAIL ror4_flags got %b want 00001", o_flags); end
        consume();
`else
        run_op(3'b011, 32'h8000_0001, 8'd4);
        checks++; if (o_data !== 32'h8000_0001) begin errors++; $display("FAIL rol_pass_data got %h want 80000001", o_data); end
        checks++; if ({o_flags, o_mask} !== 10'd0) begin errors++; $display("FAIL rol_pass_flags got %b/%b want 0", o_flags, o_mask); end
        checks++; if (o_lat !== 1) begin errors++; $display("FAIL rol_pass_latency got %0d want 1", o_lat); end
        consume();
        run_op(3'b100, 32'h0000_0001, 8'd1);
        checks++; if (o_data !== 32'h0000_0001) begin errors++; $display("FAIL ror_pass_data got %h want 00000001", o_data); end
        checks++; if (o_mask !== 5'b00000) begin errors++; $display("FAIL ror_pass_mask got %b want 00000", o_mask); end
        consume();
`endif
    endtask

    task automatic test_passthrough();
        run_op(3'b000, 32'h1234_5678, 8'h20);
        checks++; if (o_data !== 32'h1234_5678) begin errors++; $display("FAIL cnt0_data got %h want 12345678", o_data); end
        checks++; if ({o_flags, o_mask} !== 10'd0) begin errors++; $display("FAIL cnt0_flags got %b/%b want 0", o_flags, o_mask); end
        checks++; if (o_lat !== 1) begin errors++; $display("FAIL cnt0_latency got %0d want 1", o_lat); end
        consume();
        run_op(3'b111, 32'h1234_5678, 8'd4);
        checks++; if (o_data !== 32'h1234_5678) begin errors++; $display("FAIL illegal_data got %h want 12345678", o_data); end
        checks++; if (o_mask !== 5'b00000) begin errors++; $display("FAIL illegal_mask got %b want 00000", o_mask); end
        checks++; if (o_lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", o_lat); end
        consume();
    endtask

    task automatic test_hold();
        run_op(3'b000, 32'h8000_0001, 8'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (!(out_valid === 1'b1 && out_data === 32'h2 && out_flags === 5'b10001 &&
                  out_flag_mask === 5'b11111 && in_ready === 1'b0 && sh_in === '0)) begin
                errors++;
                $display("FAIL hold_cycle%0d got v=%b d=%h f=%b m=%b rdy=%b shin=%h want 1/00000002/10001/11111/0/0",
                         i, out_valid, out_data, out_flags, out_flag_mask, in_ready, sh_in);
            end
        end
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got rdy=%b v=%b want 1/0", in_ready, out_valid); end
        in_valid = 1'b1; in_op = 3'b000; in_data = 32'h1; in_cnt = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_next_accept got rdy=%b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h8) begin errors++; $display("FAIL hold_next_result got v=%b d=%h want 1/00000008", out_valid, out_data); end
        consume();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", k, in_ready); end
            in_valid = 1'b1; in_op = 3'b001; in_data = 32'h100 << k; in_cnt = 8'd8;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early%0d got %b want 0", k, out_valid); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_data !== (32'h1 << k)) begin errors++; $display("FAIL b2b_result%0d got v=%b d=%h want 1/%h", k, out_valid, out_data, 32'h1 << k); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain%0d got v=%b rdy=%b want 0/1", k, out_valid, in_ready); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_op = 3'b010; in_data = 32'h8000_0000; in_cnt = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (sh_in !== 32'h1 || sh_amt !== 5'd4 || sh_sin !== 1'b1) begin errors++; $display("FAIL sar_drive got %h/%0d/%b want 00000001/4/1", sh_in, sh_amt, sh_sin); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_flags !== '0 || out_flag_mask !== '0 || sh_in !== '0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got v=%b d=%h f=%b m=%b shin=%h rdy=%b want all 0", out_valid, out_data, out_flags, out_flag_mask, sh_in, in_ready);
        end
        rst = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_emit got %b want 0", out_valid); end
        end
`ifdef SHIFT_SEQ_ROT_EN
        in_valid = 1'b1; in_op = 3'b011; in_data = 32'h8000_0001; in_cnt = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (sh_in !== 32'h8000_0001 || sh_amt !== 5'd4) begin errors++; $display("FAIL rol_pass1_drive got %h/%0d want 80000001/4", sh_in, sh_amt); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rol_midrst got v=%b d=%h want 0/0", out_valid, out_data); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_shl();
        test_right_shifts();
        test_rotate();
        test_passthrough();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
